// File: rtl/reg_dst_pkg.sv
// Shared select codes, default fixed indices and the pipeline slot record for the destination tracker.
package reg_dst_pkg;
    localparam int SEL_SP     = 2;
    localparam int SEL_RA     = 3;
    localparam int SP_IDX_DEF = 29;
    localparam int RA_IDX_DEF = 31;
    localparam int ADDR_W_DEF = 5;

    typedef struct packed {
        logic                  vld;
        logic [ADDR_W_DEF-1:0] dst;
    } stage_t;
endpackage

// File: rtl/reg_dst_stage.sv
// One tracker slot: holds {vld,dst}, shifts on advance, clears vld on flush, and matches rs/rt.
// Latency 1 edge; advance=0 holds the slot, no backpressure of its own.
module reg_dst_stage
    import reg_dst_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    input  logic              flush,
    input  logic              in_vld,
    input  logic [ADDR_W-1:0] in_dst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              vld,
    output logic [ADDR_W-1:0] dst,
    output logic              rs_hit,
    output logic              rt_hit
);
    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= 1'b0;
            dst <= '0;
        end else if (flush) begin
            // dst is left as-is; only the valid bit matters once flushed
            vld <= 1'b0;
        end else if (advance) begin
            vld <= in_vld;
            dst <= in_dst;
        end
    end

    assign rs_hit = vld && (dst == rs_addr);
    assign rt_hit = vld && (dst == rt_addr);
endmodule

// File: rtl/reg_dst_tracker.sv
// Selects the write destination and tracks it through DEPTH slots to writeback, flagging RAW hazards.
// Latency DEPTH edges sel->wb; advance=0 freezes all slots. Option FWD_HIT_EN drives per-slot hit vectors.
module reg_dst_tracker
    import reg_dst_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int NUM_SRC = 8,
    parameter int DEPTH   = 3,
    parameter int SP_IDX  = SP_IDX_DEF,
    parameter int RA_IDX  = RA_IDX_DEF,
    localparam int SEL_W  = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [SEL_W-1:0]          sel,
    input  logic [NUM_SRC*ADDR_W-1:0] src_bus,
    input  logic                      wr_valid,
    input  logic                      advance,
    input  logic                      flush,
    input  logic [ADDR_W-1:0]         rs_addr,
    input  logic [ADDR_W-1:0]         rt_addr,
    output logic [ADDR_W-1:0]         dst_sel_q,
    output logic [ADDR_W-1:0]         wb_dst,
    output logic                      wb_valid,
    output logic                      hazard_rs,
    output logic                      hazard_rt,
    output logic [DEPTH-1:0]          fwd_rs_hit,
    output logic [DEPTH-1:0]          fwd_rt_hit
);
    logic [ADDR_W-1:0] sel_dst;
    logic              sel_vld;

    // Codes past NUM_SRC match no slot and fall through to index 0, which is never valid.
    always_comb begin
        sel_dst = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (32'(sel) == k) sel_dst = src_bus[k*ADDR_W +: ADDR_W];
        end
        if (32'(sel) == SEL_SP) sel_dst = ADDR_W'(SP_IDX);
        if (32'(sel) == SEL_RA) sel_dst = ADDR_W'(RA_IDX);
    end

    assign sel_vld = wr_valid && (sel_dst != '0);

    logic              stg_vld  [DEPTH];
    logic [ADDR_W-1:0] stg_dst  [DEPTH];
    logic              nxt_vld  [DEPTH];
    logic [ADDR_W-1:0] nxt_dst  [DEPTH];
    logic [DEPTH-1:0]  rs_hit;
    logic [DEPTH-1:0]  rt_hit;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        if (i == 0) begin : g_head
            assign nxt_vld[i] = sel_vld;
            assign nxt_dst[i] = sel_dst;
        end else begin : g_tail
            assign nxt_vld[i] = stg_vld[i-1];
            assign nxt_dst[i] = stg_dst[i-1];
        end

        reg_dst_stage #(.ADDR_W(ADDR_W)) u_stage (
            .clk     (clk),
            .reset   (reset),
            .advance (advance),
            .flush   (flush),
            .in_vld  (nxt_vld[i]),
            .in_dst  (nxt_dst[i]),
            .rs_addr (rs_addr),
            .rt_addr (rt_addr),
            .vld     (stg_vld[i]),
            .dst     (stg_dst[i]),
            .rs_hit  (rs_hit[i]),
            .rt_hit  (rt_hit[i])
        );
    end

    logic rs_nz;
    logic rt_nz;
    assign rs_nz = (rs_addr != '0);
    assign rt_nz = (rt_addr != '0);

    assign dst_sel_q = stg_dst[0];
    assign wb_dst    = stg_dst[DEPTH-1];
    assign wb_valid  = stg_vld[DEPTH-1];
    // The writeback slot is included: the register file writes on the same edge the operand is read.
    assign hazard_rs = rs_nz && (|rs_hit);
    assign hazard_rt = rt_nz && (|rt_hit);

`ifdef FWD_HIT_EN
    assign fwd_rs_hit = rs_hit & {DEPTH{rs_nz}};
    assign fwd_rt_hit = rt_hit & {DEPTH{rt_nz}};
`else
    assign fwd_rs_hit = '0;
    assign fwd_rt_hit = '0;
`endif
endmodule

// File: tb/tb_reg_dst_tracker.sv
// Scoreboard bench for reg_dst_tracker: directed scenarios followed by randomized traffic.
module tb_reg_dst_tracker;
    localparam int ADDR_W  = 5;
    localparam int NUM_SRC = 8;
    localparam int DEPTH   = 3;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic [2:0]                sel = '0;
    logic [NUM_SRC*ADDR_W-1:0] src_bus = '0;
    logic                      wr_valid = 1'b0;
    logic                      advance = 1'b0;
    logic                      flush = 1'b0;
    logic [ADDR_W-1:0]         rs_addr = '0;
    logic [ADDR_W-1:0]         rt_addr = '0;
    logic [ADDR_W-1:0]         dst_sel_q;
    logic [ADDR_W-1:0]         wb_dst;
    logic                      wb_valid;
    logic                      hazard_rs;
    logic                      hazard_rt;
    logic [DEPTH-1:0]          fwd_rs_hit;
    logic [DEPTH-1:0]          fwd_rt_hit;

    reg_dst_tracker #(.ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .sel        (sel),
        .src_bus    (src_bus),
        .wr_valid   (wr_valid),
        .advance    (advance),
        .flush      (flush),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .dst_sel_q  (dst_sel_q),
        .wb_dst     (wb_dst),
        .wb_valid   (wb_valid),
        .hazard_rs  (hazard_rs),
        .hazard_rt  (hazard_rt),
        .fwd_rs_hit (fwd_rs_hit),
        .fwd_rt_hit (fwd_rt_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit vld;
        int dst;
    } ent_t;

    typedef struct {
        string name;
        int    dsq;
        int    wbd;
        int    wbv;
        int    hrs;
        int    hrt;
        int    frs;
        int    frt;
    } exp_t;

    ent_t pipe[$];      // index 0 = youngest (slot 0), last = writeback slot
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input string field, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s.%s: got %0d expected %0d", name, field, act, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the reference model, queue the post-edge expectation.
    task automatic step(input bit rst, input int s, input bit wv, input bit adv, input bit fl,
                        input int rs, input int rt, input logic [NUM_SRC*ADDR_W-1:0] bus,
                        input string name);
        ent_t e;
        exp_t x;
        int   chosen;
        @(negedge clk);
        reset    = rst;
        sel      = 3'(s);
        wr_valid = wv;
        advance  = adv;
        flush    = fl;
        rs_addr  = 5'(rs);
        rt_addr  = 5'(rt);
        src_bus  = bus;

        if (s == 2)      chosen = 29;
        else if (s == 3) chosen = 31;
        else             chosen = int'(bus[s*ADDR_W +: ADDR_W]);

        if (rst) begin
            pipe = {};
            repeat (DEPTH) pipe.push_back('{vld: 1'b0, dst: 0});
        end else if (fl) begin
            foreach (pipe[i]) pipe[i].vld = 1'b0;
        end else if (adv) begin
            e.vld = wv && (chosen != 0);
            e.dst = chosen;
            pipe.push_front(e);
            void'(pipe.pop_back());
        end

        x.name = name;
        x.dsq  = pipe[0].dst;
        x.wbd  = pipe[DEPTH-1].dst;
        x.wbv  = pipe[DEPTH-1].vld;
        x.frs  = 0;
        x.frt  = 0;
        foreach (pipe[i]) begin
            if (rs != 0 && pipe[i].vld && pipe[i].dst == rs) x.frs |= (1 << i);
            if (rt != 0 && pipe[i].vld && pipe[i].dst == rt) x.frt |= (1 << i);
        end
        x.hrs = (x.frs != 0);
        x.hrt = (x.frt != 0);
`ifndef FWD_HIT_EN
        x.frs = 0;
        x.frt = 0;
`endif
        sb.push_back(x);
    endtask

    // Monitor: outputs are sampled 1 time unit after each rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check(x.name, "dst_sel_q",  int'(dst_sel_q),  x.dsq);
                check(x.name, "wb_dst",     int'(wb_dst),     x.wbd);
                check(x.name, "wb_valid",   int'(wb_valid),   x.wbv);
                check(x.name, "hazard_rs",  int'(hazard_rs),  x.hrs);
                check(x.name, "hazard_rt",  int'(hazard_rt),  x.hrt);
                check(x.name, "fwd_rs_hit", int'(fwd_rs_hit), x.frs);
                check(x.name, "fwd_rt_hit", int'(fwd_rt_hit), x.frt);
            end
        end
    end

    function automatic logic [NUM_SRC*ADDR_W-1:0] bus_with0(input int v);
        logic [NUM_SRC*ADDR_W-1:0] b;
        b = '0;
        b[ADDR_W-1:0] = 5'(v);
        return b;
    endfunction

    initial begin
        logic [NUM_SRC*ADDR_W-1:0] rb;
        int budget;
        repeat (DEPTH) pipe.push_back('{vld: 1'b0, dst: 0});

        step(1, 0, 0, 0, 0, 0, 0, '0, "reset");
        repeat (3) step(0, 3, 1, 1, 0, 0, 0, '0, "ra_fill");
        step(0, 0, 1, 1, 0, 9, 0, bus_with0(9), "rs_hit9");
        step(0, 0, 1, 1, 0, 0, 0, bus_with0(0), "zero_dst");
        step(0, 0, 1, 1, 0, 0, 0, bus_with0(0), "zero_rs");
        step(0, 0, 1, 1, 0, 0, 12, bus_with0(12), "load12");
        step(0, 0, 1, 1, 0, 0, 12, bus_with0(5), "slot1_12");
        repeat (2) step(0, 0, 1, 0, 0, 0, 12, bus_with0(7), "stall");
        step(0, 0, 1, 1, 1, 0, 12, bus_with0(7), "flush");
        repeat (3) step(0, 2, 1, 1, 0, 29, 0, '0, "sp_fill");
        step(1, 3, 1, 1, 1, 29, 31, '0, "reset_mid");
        step(0, 1, 1, 1, 0, 29, 0, '0, "post_reset");

        for (int n = 0; n < 400; n++) begin
            rb = '0;
            for (int k = 0; k < NUM_SRC; k++) rb[k*ADDR_W +: ADDR_W] = 5'($urandom_range(0, 7));
            step(($urandom_range(0, 40) == 0),
                 int'($urandom_range(0, NUM_SRC - 1)),
                 ($urandom_range(0, 5) != 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) == 0) ? 29 : int'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) == 0) ? 31 : int'($urandom_range(0, 7)),
                 rb, "random");
        end

        budget = 20;
        while (sb.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
